result_encoder: RTL and testbench
=================================

# result_encoder

Formats a calculator result into an ASCII hex line and streams it byte-by-byte to the UART transmitter. It sits between the arithmetic unit and the UART TX, mirroring the command decoder on the receive side. Output characters use the same alphabet the decoder accepts: `0`–`9`, `A`–`F`, and `-`. Each line ends with CR LF; an error request emits `ERR` CR LF instead.

## Interface
- NIBBLES, 8: number of hex digits in the result; result width is 4*NIBBLES.
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- result  in  4*NIBBLES  value to print; sampled on the accepted start.
- signed_mode  in  1  treat result as two's complement; sampled with start.
- err  in  1  print `ERR` instead of the value; sampled with start.
- tx_data  out  8  character to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte; a transfer occurs when tx_valid and tx_ready are both high.
- busy  out  1  a line is in progress.
- done  out  1  one-cycle pulse after the LF transfer.

## Operation
- FSM states: IDLE, SIGN, DIGIT, ERR, CR, LF.
- **IDLE, start=1:**
  - Latch err, signed_mode and the magnitude register.
  - Magnitude is 0 − result (modulo 2^(4*NIBBLES)) when signed_mode=1 and the result MSB is 1; otherwise it is result.
  - The most negative value maps to itself and prints as `-8000…`.
  - Next state: ERR if err=1; else SIGN if the value is negative; else DIGIT.
- **Digit index:**
  - Loaded at latch time from a priority encoder: the index of the most significant nonzero nibble, or 0 if the magnitude is 0.
  - This suppresses leading zeros with no bubble cycles and always emits at least one digit.
- **SIGN:** emit 0x2D (`-`), then go to DIGIT.
- **DIGIT:**
  - Emit the ASCII code of the nibble at the digit index: 0–9 map to 0x30–0x39, A–F map to 0x41–0x46 (uppercase).
  - The index decrements on each transfer; go to CR after the index-0 transfer.
- **ERR:** emit 0x45, 0x52, 0x52 using a 2-bit counter, then go to CR.
- **CR:** emit 0x0D, then go to LF.
- **LF:** emit 0x0A; on transfer, pulse done and go to IDLE.
- **Handshake:**
  - The state advances only on a transfer.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold steady.
  - tx_valid never drops before a transfer.
- start asserted outside IDLE is ignored; it is not queued.
- A start in the same cycle as done (the IDLE transition) is not accepted. The earliest accepted start is the cycle after done.
- Reset values: tx_data=0x00, tx_valid=0, busy=0, done=0, state=IDLE, all internal registers 0.
- Reset mid-line aborts immediately. The partial line is not completed, and no done pulse is produced.

## Timing
- All outputs are registered.
- A start accepted at edge N gives tx_valid=1 and busy=1 from cycle N+1 with the first character.
- With tx_ready held high, throughput is one character per cycle with no gaps.
- Line length L = sign(0/1) + digits(1..NIBBLES) + 2, or 5 for error lines.
- After the LF transfer at edge M:
  - done=1 and busy=0 during cycle M+1.
  - tx_valid=0 during cycle M+1.
- Latency from start to done is L+1 cycles when tx_ready is held high.

## Structure
- Shared package `calc_pkg`:
  - ASCII constants: CHR_MINUS 0x2D, CHR_CR 0x0D, CHR_LF 0x0A, CHR_E 0x45, CHR_R 0x52.
  - FSM state encoding.
- These constants are shared with the decoder.
- Sub-module `hex2ascii`: 4-bit in, 8-bit out, combinational, instantiated once for the digit path.
- Priority encoder and FSM stay in `result_encoder`.

## Test plan
- Unsigned 0x00001A3F, tx_ready=1 → bytes 31 41 33 46 0D 0A on consecutive cycles; done one cycle after 0A; no leading 30s.
- Result 0x00000000, either mode → 30 0D 0A.
- signed_mode=1, 0xFFFFFFFE → 2D 32 0D 0A. Same value with signed_mode=0 → 46 46 46 46 46 46 46 45 0D 0A. Signed 0x80000000 → 2D 38 30 30 30 30 30 30 30 0D 0A.
- err=1 (any result) → 45 52 52 0D 0A, then done.
- Backpressure:
  - tx_ready low for 3 cycles mid-digit, random thereafter → tx_data stable while stalled, no byte lost or repeated.
  - start pulsed while busy → ignored; the line is unchanged.
- n_rst asserted after the second byte → outputs 0 immediately, no done. A subsequent start of 0x5 → 35 0D 0A.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants and encoder state encoding
package calc_pkg;

    localparam logic [7:0] CHR_MINUS = 8'h2D;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_E     = 8'h45;
    localparam logic [7:0] CHR_R     = 8'h52;
    localparam logic [7:0] CHR_0     = 8'h30;
    // 'A' minus 10, so a nibble of 10..15 lands on 'A'..'F'
    localparam logic [7:0] CHR_A_OFS = 8'h37;

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        DIGIT,
        ERR,
        CR,
        LF
    } enc_state_t;

endpackage

// File: rtl/result_encoder_if.sv
// rtl/result_encoder_if.sv - byte stream from the result encoder to the UART transmitter
interface result_encoder_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/hex2ascii.sv
// rtl/hex2ascii.sv - one hex nibble to its uppercase ASCII character
module hex2ascii
   import calc_pkg::*;
(
   input  logic [3:0] nib,
   output logic [7:0] chr
);

   assign chr = (nib < 4'd10) ? (CHR_0 + {4'h0, nib}) : (CHR_A_OFS + {4'h0, nib});

endmodule

// File: rtl/result_encoder.sv
// rtl/result_encoder.sv - prints a result as an ASCII hex line (or ERR) over a byte stream
module result_encoder
   import calc_pkg::*;
#(
   parameter int NIBBLES = 8
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   result,
   input  logic                   signed_mode,
   input  logic                   err,
   output logic                   busy,
   output logic                   done,
   result_encoder_if.master       tx
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   enc_state_t    state, state_n;
   logic [W-1:0]  mag, mag_n;
   logic [IW-1:0] idx, idx_n;
   logic [1:0]    cnt, cnt_n;
   logic [7:0]    tx_data_n;
   logic          tx_valid_n, busy_n, done_n;
   logic [W-1:0]  mag_sh;
   logic [7:0]    digit_chr;
   logic          xfer;

   assign xfer = tx.tx_valid && tx.tx_ready;

   function automatic logic [IW-1:0] msn_index(input logic [W-1:0] v);
      msn_index = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (v[4*i +: 4] != 4'h0) msn_index = IW'(i);
      end
   endfunction

   always_comb begin
      state_n = state;
      mag_n   = mag;
      idx_n   = idx;
      cnt_n   = cnt;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            // the done cycle is still IDLE, but a start there is deliberately dropped
            if (start && !done) begin
               mag_n = (signed_mode && result[W-1]) ? (~result + W'(1)) : result;
               idx_n = msn_index(mag_n);
               cnt_n = 2'd0;
               if (err)                              state_n = ERR;
               else if (signed_mode && result[W-1])  state_n = SIGN;
               else                                  state_n = DIGIT;
            end
         end
         SIGN:  if (xfer) state_n = DIGIT;
         DIGIT: begin
            if (xfer) begin
               if (idx == '0) state_n = CR;
               else           idx_n   = idx - IW'(1);
            end
         end
         ERR: begin
            if (xfer) begin
               if (cnt == 2'd2) begin
                  state_n = CR;
                  cnt_n   = 2'd0;
               end else begin
                  cnt_n = cnt + 2'd1;
               end
            end
         end
         CR: if (xfer) state_n = LF;
         LF: begin
            if (xfer) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // the digit path looks at the next-cycle nibble so the byte is ready as the state is entered
   assign mag_sh = mag_n >> {idx_n, 2'b00};

   hex2ascii u_hex2ascii (
      .nib (mag_sh[3:0]),
      .chr (digit_chr)
   );

   always_comb begin
      tx_data_n  = 8'h00;
      tx_valid_n = 1'b1;
      busy_n     = 1'b1;
      case (state_n)
         IDLE: begin
            tx_valid_n = 1'b0;
            busy_n     = 1'b0;
         end
         SIGN:    tx_data_n = CHR_MINUS;
         DIGIT:   tx_data_n = digit_chr;
         ERR:     tx_data_n = (cnt_n == 2'd0) ? CHR_E : CHR_R;
         CR:      tx_data_n = CHR_CR;
         LF:      tx_data_n = CHR_LF;
         default: tx_data_n = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         mag         <= '0;
         idx         <= '0;
         cnt         <= 2'd0;
         tx.tx_data  <= 8'h00;
         tx.tx_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         mag         <= mag_n;
         idx         <= idx_n;
         cnt         <= cnt_n;
         tx.tx_data  <= tx_data_n;
         tx.tx_valid <= tx_valid_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

endmodule

// File: tb/tb_result_encoder.sv
// tb/tb_result_encoder.sv - directed scoreboard bench for result_encoder
module tb_result_encoder;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [31:0] result;
   logic        signed_mode;
   logic        err;
   logic        busy;
   logic        done;

   result_encoder_if tx_if ();

   result_encoder #(.NIBBLES(8)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .result      (result),
      .signed_mode (signed_mode),
      .err         (err),
      .busy        (busy),
      .done        (done),
      .tx          (tx_if)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   logic [7:0] exp_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // reference line builder: walks the digits most-significant first and drops leading zeros
   task automatic push_model(input logic [31:0] r, input bit sm, input bit e);
      string       hx;
      logic [31:0] m;
      logic [3:0]  n;
      bit          lead;
      hx = "0123456789ABCDEF";
      if (e) begin
         exp_q.push_back(8'h45);
         exp_q.push_back(8'h52);
         exp_q.push_back(8'h52);
      end else begin
         m = (sm && r[31]) ? (32'd0 - r) : r;
         if (sm && r[31]) exp_q.push_back(8'h2D);
         lead = 1'b1;
         for (int i = 7; i >= 0; i--) begin
            n = 4'(m >> (4 * i));
            if (n != 4'h0 || i == 0) lead = 1'b0;
            if (!lead) exp_q.push_back(8'(hx[n]));
         end
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   always @(negedge clk) begin
      if (!n_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            assert (tx_if.tx_valid === 1'b1 && tx_if.tx_data === prev_data) else begin
               bad++;
               $error("FAIL stall_hold got valid=%0b data=%02h want valid=1 data=%02h",
                      tx_if.tx_valid, tx_if.tx_data, prev_data);
            end
         end
         if (tx_if.tx_valid && tx_if.tx_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
               bad++;
               $error("FAIL extra_byte got=%02h want=none", tx_if.tx_data);
            end
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               total++;
               assert (tx_if.tx_data === exp_b) else begin
                  bad++;
                  $error("FAIL tx_byte got=%02h want=%02h", tx_if.tx_data, exp_b);
               end
            end
         end
         prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
         prev_data  = tx_if.tx_data;
      end
   end

   // mode 0: ready high; mode 1: 3-cycle stall then random ready; mode 2: extra start while busy
   task automatic run_line(input logic [31:0] r, input bit sm, input bit e, input int lat, input int mode);
      int cyc;
      bit seen;
      push_model(r, sm, e);
      start       = 1'b1;
      result      = r;
      signed_mode = sm;
      err         = e;
      tx_if.tx_ready = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            check("busy_after_start", 32'(busy), 32'd1);
            check("valid_after_start", 32'(tx_if.tx_valid), 32'd1);
         end
         if (mode == 1) begin
            if (cyc >= 3 && cyc <= 5) tx_if.tx_ready = 1'b0;
            else if (cyc > 5)         tx_if.tx_ready = 1'($urandom_range(0, 1));
         end
         if (mode == 2 && cyc == 2) begin
            start  = 1'b1;
            result = 32'h0000DEAD;
         end else if (mode == 2 && cyc == 3) begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
      if (lat > 0) check("latency", 32'(cyc), 32'(lat));
      check("busy_at_done", 32'(busy), 32'd0);
      check("valid_at_done", 32'(tx_if.tx_valid), 32'd0);
      check("line_complete", 32'(exp_q.size()), 32'd0);
      tx_if.tx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_line", 32'(tx_if.tx_valid), 32'd0);
   endtask

   initial begin
      n_rst          = 1'b0;
      start          = 1'b0;
      result         = 32'h0;
      signed_mode    = 1'b0;
      err            = 1'b0;
      tx_if.tx_ready = 1'b1;
      #12;
      check("rst_tx_data", 32'(tx_if.tx_data), 32'h00);
      check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      run_line(32'h00001A3F, 1'b0, 1'b0, 7, 0);
      run_line(32'h00000000, 1'b0, 1'b0, 4, 0);
      run_line(32'h00000000, 1'b1, 1'b0, 4, 0);
      run_line(32'hFFFFFFFE, 1'b1, 1'b0, 5, 0);
      run_line(32'hFFFFFFFE, 1'b0, 1'b0, 11, 0);
      run_line(32'h80000000, 1'b1, 1'b0, 12, 0);
      run_line(32'h00001234, 1'b0, 1'b1, 6, 0);
      run_line(32'h00ABC123, 1'b0, 1'b0, -1, 1);
      run_line(32'h00000042, 1'b0, 1'b0, 5, 2);

      // abort mid-line: two bytes out, then reset
      push_model(32'h00000123, 1'b0, 1'b0);
      start  = 1'b1;
      result = 32'h00000123;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      check("abort_tx_data", 32'(tx_if.tx_data), 32'h00);
      check("abort_tx_valid", 32'(tx_if.tx_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_left", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
         check("abort_no_done", 32'(done), 32'd0);
      end
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      run_line(32'h00000005, 1'b0, 1'b0, 4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
